// File: rtl/booth_multiplier_if.sv
// Operand/result bundle for the radix-2 Booth multiplier: launch request,
// signed operands in, registered product and completion flag out.
interface booth_multiplier_if;
  logic              start;
  logic signed [7:0] multiplicand;
  logic signed [7:0] multiplier;
  logic       [15:0] outbus;
  logic              done;

  modport master (
    output start, multiplicand, multiplier,
    input  outbus, done
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output outbus, done
  );
endinterface

// File: rtl/booth_multiplier.sv
// Sequential 8x8 signed multiplier, radix-2 Booth recoding, one iteration per
// clock; fixed 9-cycle latency from the launch edge to done.
module booth_multiplier (
  input  logic                       clk,
  input  logic                       rst,
  booth_multiplier_if.slave          bus
);

  typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;

  state_t      state_q, state_d;
  logic [8:0]  a_q, a_d;
  logic [7:0]  q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [8:0]  m_q, m_d;
  logic [3:0]  count_q, count_d;
  logic [15:0] outbus_q, outbus_d;
  logic        done_q, done_d;
  logic [8:0]  sum;
  logic        launch;

  assign bus.outbus = outbus_q;
  assign bus.done   = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      count_q  <= '0;
      outbus_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      m_q      <= m_d;
      count_q  <= count_d;
      outbus_q <= outbus_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    m_d      = m_q;
    count_d  = count_q;
    outbus_d = outbus_q;
    done_d   = done_q;
    sum      = a_q;
    launch   = bus.start && ((state_q == IDLE) || done_q);

    case (state_q)
      IDLE: begin
        if (launch) begin
          a_d     = '0;
          q_d     = bus.multiplier;
          qm1_d   = 1'b0;
          m_d     = {bus.multiplicand[7], bus.multiplicand};
          count_d = '0;
          done_d  = 1'b0;
          state_d = ITER;
        end
      end
      ITER: begin
        case ({q_q[0], qm1_q})
          2'b10:   sum = a_q - m_q;
          2'b01:   sum = a_q + m_q;
          default: sum = a_q;
        endcase
        // Arithmetic right shift of the whole {A, Q, Q-1} register.
        {a_d, q_d, qm1_d} = {sum[8], sum, q_q};
        count_d = count_q + 4'd1;
        if (count_q == 4'd7) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        outbus_d = {a_q[7:0], q_q};
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed scenarios plus random
// operand pairs checked against plain signed multiplication.
module tb_booth_multiplier;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  booth_multiplier_if bus ();

  booth_multiplier dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_product(input logic signed [7:0] m,
                                              input logic signed [7:0] q);
    int p;
    p = int'(m) * int'(q);
    return p[15:0];
  endfunction

  // Launch one operation with a one-cycle start pulse and wait (bounded) for done.
  task automatic run_op(input logic signed [7:0] m, input logic signed [7:0] q,
                        output logic [15:0] res, output int lat,
                        output logic done_at_launch);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    @(posedge clk);
    #1;
    done_at_launch = bus.done;
    bus.start      = 1'b0;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.outbus;
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.outbus !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL reset_outbus got=%h want=0000", bus.outbus);
    end
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_done got=%b want=0", bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] res;
    int          lat;
    logic        dl;
    run_op(8'sd10, 8'sd5, res, lat, dl);
    total++;
    if (res !== 16'h0032) begin
      bad++;
      $display("[TB] FAIL basic_result got=%h want=0032", res);
    end
    total++;
    if (lat !== 9) begin
      bad++;
      $display("[TB] FAIL basic_latency got=%0d want=9", lat);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b1 || bus.outbus !== 16'h0032) begin
      bad++;
      $display("[TB] FAIL basic_hold got=%b/%h want=1/0032", bus.done, bus.outbus);
    end
  endtask

  task automatic test_table(input string name, input logic signed [7:0] ms[],
                            input logic signed [7:0] qs[]);
    logic [15:0] res;
    int          lat;
    logic        dl;
    for (int i = 0; i < ms.size(); i++) begin
      run_op(ms[i], qs[i], res, lat, dl);
      total++;
      if (res !== ref_product(ms[i], qs[i])) begin
        bad++;
        $display("[TB] FAIL %s_result[%0d] got=%h want=%h", name, i, res,
                 ref_product(ms[i], qs[i]));
      end
      total++;
      if (dl !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s_done_drop[%0d] got=%b want=0", name, i, dl);
      end
      total++;
      if (lat !== 9) begin
        bad++;
        $display("[TB] FAIL %s_latency[%0d] got=%0d want=9", name, i, lat);
      end
    end
  endtask

  task automatic test_sequential();
    logic signed [7:0] ms[] = '{-8'sd3, 8'sd4, -8'sd5, -8'sd8};
    logic signed [7:0] qs[] = '{8'sd7, -8'sd6, -8'sd5, 8'sd0};
    test_table("seq", ms, qs);
  endtask

  task automatic test_extremes();
    logic signed [7:0] ms[] = '{-8'sd128, -8'sd128, 8'sd127, 8'sd127};
    logic signed [7:0] qs[] = '{-8'sd128, 8'sd127, 8'sd127, -8'sd128};
    test_table("ext", ms, qs);
  endtask

  // Operands change and start re-pulses mid-computation; neither may disturb the result.
  task automatic test_operand_change();
    logic [15:0] prev;
    int          lat;
    prev = bus.outbus;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 8'sd6;
    bus.multiplier   = 8'sd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      lat++;
    end
    bus.multiplicand = -8'sd1;
    bus.multiplier   = -8'sd1;
    bus.start        = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    lat++;
    total++;
    if (bus.outbus !== prev) begin
      bad++;
      $display("[TB] FAIL chg_outbus_held got=%h want=%h", bus.outbus, prev);
    end
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (bus.outbus !== ref_product(8'sd6, 8'sd7)) begin
      bad++;
      $display("[TB] FAIL chg_result got=%h want=%h", bus.outbus, ref_product(8'sd6, 8'sd7));
    end
    total++;
    if (lat !== 9) begin
      bad++;
      $display("[TB] FAIL chg_latency got=%0d want=9", lat);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL chg_no_relaunch got=%b want=1", bus.done);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] res;
    int          lat;
    logic        dl;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 8'sd100;
    bus.multiplier   = 8'sd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (bus.outbus !== 16'h0000 || bus.done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs got=%h/%b want=0000/0", bus.outbus, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0 || bus.outbus !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL midreset_abandoned got=%b/%h want=0/0000", bus.done, bus.outbus);
    end
    run_op(8'sd10, 8'sd5, res, lat, dl);
    total++;
    if (res !== 16'h0032 || lat !== 9) begin
      bad++;
      $display("[TB] FAIL midreset_relaunch got=%h lat=%0d want=0032 lat=9", res, lat);
    end
  endtask

  // Start held high: launches once, then relaunches on the edge after done.
  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = -8'sd9;
    bus.multiplier   = 8'sd11;
    @(posedge clk);
    #1;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat !== 9 || bus.outbus !== ref_product(-8'sd9, 8'sd11)) begin
      bad++;
      $display("[TB] FAIL b2b_first got=%h lat=%0d want=%h lat=9", bus.outbus, lat,
               ref_product(-8'sd9, 8'sd11));
    end
    bus.multiplicand = 8'sd13;
    bus.multiplier   = -8'sd12;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_relaunch_drop got=%b want=0", bus.done);
    end
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat !== 9 || bus.outbus !== ref_product(8'sd13, -8'sd12)) begin
      bad++;
      $display("[TB] FAIL b2b_second got=%h lat=%0d want=%h lat=9", bus.outbus, lat,
               ref_product(8'sd13, -8'sd12));
    end
  endtask

  task automatic test_random();
    logic signed [7:0] m, q;
    logic [15:0]       res;
    int                lat;
    logic              dl;
    for (int i = 0; i < 1000; i++) begin
      m = 8'($urandom);
      q = 8'($urandom);
      run_op(m, q, res, lat, dl);
      total++;
      if (res !== ref_product(m, q) || lat !== 9 || dl !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rand[%0d] %0d*%0d got=%h lat=%0d drop=%b want=%h lat=9 drop=0",
                 i, m, q, res, lat, dl, ref_product(m, q));
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_sequential();
    test_extremes();
    test_operand_change();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
